// File: rtl/regs_pkg.sv
// Shared widths and the write-request bundle used by both writers
// of the register file port.
package regs_pkg;

    localparam int XLEN       = 64;
    localparam int NREG       = 32;
    localparam int AW         = 5;
    localparam int STARVE_MAX = 4;
    localparam int CW         = 3;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] addr;
        logic [XLEN-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regs_scoreboard.sv
// Busy bits for registers with an MDU result still outstanding,
// plus the three ID-stage lookups.
module regs_scoreboard
    import regs_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic [AW-1:0] rd,
    output logic          hit
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // clear first so a same-register set in the same cycle wins
    always_comb begin
        busy_d = busy_q;
        if (clr_en)
            busy_d[clr_addr] = 1'b0;
        if (set_en)
            busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign hit = busy_q[rs1] | busy_q[rs2] | busy_q[rd];

endmodule

// File: rtl/regs_wport_arbiter.sv
// Single register-file write port shared by WB and a one-entry
// MDU hold buffer, with starvation relief and a busy scoreboard.
module regs_wport_arbiter
    import regs_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_wen_i,
    input  logic [AW-1:0]   wb_waddr_i,
    input  logic [XLEN-1:0] wb_wdata_i,
    input  logic            md_valid_i,
    output logic            md_ready_o,
    input  logic [AW-1:0]   md_waddr_i,
    input  logic [XLEN-1:0] md_wdata_i,
    input  logic            issue_i,
    input  logic [AW-1:0]   issue_rd_i,
    input  logic [AW-1:0]   reg1_raddr_i,
    input  logic [AW-1:0]   reg2_raddr_i,
    input  logic [AW-1:0]   id_rd_i,
    output logic            hazard_o,
    output logic            stall_o,
    output logic            reg_wen,
    output logic [AW-1:0]   reg_waddr_o,
    output logic [XLEN-1:0] reg_wdata_o
);

    wr_req_t       wb_req;
    wr_req_t       md_req;
    wr_req_t       hold_q;
    wr_req_t       wr;
    logic [CW-1:0] cnt_q;
    logic          starved;
    logic          hold_win;
    logic          accept;
    logic          sel_hold;
    logic          sel_wb;
    logic          sb_hit;

    assign wb_req = '{valid: wb_wen_i && (wb_waddr_i != '0),
                      addr:  wb_waddr_i,
                      data:  wb_wdata_i};

    assign md_req = '{valid: md_valid_i && (md_waddr_i != '0),
                      addr:  md_waddr_i,
                      data:  md_wdata_i};

    // starved depends only on registered state
    assign starved  = hold_q.valid && (cnt_q == CW'(STARVE_MAX));
    assign hold_win = hold_q.valid && (starved || !wb_req.valid);
    assign accept   = !hold_q.valid && md_valid_i;
    assign sel_hold = !rst && hold_win;
    assign sel_wb   = !rst && !hold_win && wb_req.valid;

    always_comb begin
        wr = '0;
        unique case (1'b1)
            sel_hold: wr = hold_q;
            sel_wb:   wr = wb_req;
            default:  wr = '0;
        endcase
    end

    assign reg_wen     = wr.valid;
    assign reg_waddr_o = wr.addr;
    assign reg_wdata_o = wr.data;
    assign md_ready_o  = !rst && !hold_q.valid;
    assign stall_o     = !rst && starved;

    // an x0 result is accepted but loads with valid=0
    always_ff @(posedge clk) begin
        if (rst)
            hold_q <= '0;
        else if (hold_win)
            hold_q <= '0;
        else if (accept)
            hold_q <= md_req;
    end

    always_ff @(posedge clk) begin
        if (rst || !hold_q.valid || hold_win)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + CW'(1);
    end

    regs_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue_i && (issue_rd_i != '0)),
        .set_addr (issue_rd_i),
        .clr_en   (hold_win),
        .clr_addr (hold_q.addr),
        .rs1      (reg1_raddr_i),
        .rs2      (reg2_raddr_i),
        .rd       (id_rd_i),
        .hit      (sb_hit)
    );

    assign hazard_o = !rst && sb_hit;

endmodule
